// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: opcodes, FSM states,
// write-back source encodings and instruction field positions.
package cpu_pkg;

  localparam int INSTR_W = 21;

  localparam int OPC_MSB = 20;
  localparam int OPC_LSB = 17;
  localparam int OP1_MSB = 16;
  localparam int OP1_LSB = 14;
  localparam int OP2_MSB = 13;
  localparam int OP2_LSB = 11;
  localparam int OP3_MSB = 10;
  localparam int OP3_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_ALU_MIN = 4'b0001;
  localparam logic [3:0] OP_ALU_MAX = 4'b0111;
  localparam logic [3:0] OP_LI      = 4'b1000;
  localparam logic [3:0] OP_LD      = 4'b1001;
  localparam logic [3:0] OP_ST      = 4'b1010;
  localparam logic [3:0] OP_JMP     = 4'b1011;
  localparam logic [3:0] OP_BZ      = 4'b1100;
  localparam logic [3:0] OP_HLT     = 4'b1111;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_IMM = 2'd1;
  localparam logic [1:0] WB_SEL_RAM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic is_li;
    logic is_ld;
    logic is_st;
    logic is_jmp;
    logic is_bz;
    logic is_hlt;
    logic is_illegal;
  } op_class_t;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath,
// program memory and data RAM (slave).
interface cpu_sequencer_if #(
  parameter int PC_W = 4
);
  logic              start;
  logic [20:0]       instr;
  logic              mem_ready;
  logic              zero_flag;
  logic [PC_W-1:0]   pc;
  logic              imem_rd_en;
  logic [3:0]        opcode;
  logic [2:0]        op1;
  logic [2:0]        op2;
  logic [2:0]        op3;
  logic [7:0]        imm;
  logic              alu_en;
  logic              rf_wr_en;
  logic [1:0]        rf_wr_sel;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              busy;
  logic              halted;
  logic              illegal;

  modport master (
    input  start, instr, mem_ready, zero_flag,
    output pc, imem_rd_en, opcode, op1, op2, op3, imm, alu_en, rf_wr_en,
           rf_wr_sel, mem_rd_en, mem_wr_en, busy, halted, illegal
  );

  modport slave (
    output start, instr, mem_ready, zero_flag,
    input  pc, imem_rd_en, opcode, op1, op2, op3, imm, alu_en, rf_wr_en,
           rf_wr_sel, mem_rd_en, mem_wr_en, busy, halted, illegal
  );
endinterface

// File: rtl/cpu_sequencer_decode.sv
// Combinational opcode classifier. Branch opcodes are recognised only when
// CPU_SEQ_BRANCH_EN is defined; otherwise they classify as illegal.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output op_class_t  cls_o
);

  // One-hot class of the opcode; anything unrecognised is illegal
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_NOP: cls_o = '0;
      OP_LI:  cls_o.is_li  = 1'b1;
      OP_LD:  cls_o.is_ld  = 1'b1;
      OP_ST:  cls_o.is_st  = 1'b1;
`ifdef CPU_SEQ_BRANCH_EN
      OP_JMP: cls_o.is_jmp = 1'b1;
      OP_BZ:  cls_o.is_bz  = 1'b1;
`endif
      OP_HLT: cls_o.is_hlt = 1'b1;
      default: begin
        if ((opcode_i >= OP_ALU_MIN) && (opcode_i <= OP_ALU_MAX)) begin
          cls_o.is_alu = 1'b1;
        end else begin
          cls_o.is_illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM and program counter for the 8-bit core. All outputs
// are registered; branch support depends on CPU_SEQ_BRANCH_EN (see instr_decode).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  cpu_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;

  logic [3:0] opcode_q, opcode_d;
  logic [2:0] op1_q, op1_d;
  logic [2:0] op2_q, op2_d;
  logic [2:0] op3_q, op3_d;
  logic [7:0] imm_q, imm_d;

  logic       imem_rd_en_q, imem_rd_en_d;
  logic       alu_en_q, alu_en_d;
  logic       rf_wr_en_q, rf_wr_en_d;
  logic [1:0] rf_wr_sel_q, rf_wr_sel_d;
  logic       mem_rd_en_q, mem_rd_en_d;
  logic       mem_wr_en_q, mem_wr_en_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  op_class_t  cls;

  assign pc_inc    = pc_q + PC_ONE;
  assign br_target = bus.instr[IMM_LSB +: PC_W];

  // Field registers load only in DECODE; decoding opcode_d lets the class
  // seen on the DECODE edge come straight from the program memory word
  always_comb begin
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op3_d    = op3_q;
    imm_d    = imm_q;
    if (state_q == S_DECODE) begin
      opcode_d = instr_opcode(bus.instr);
      op1_d    = bus.instr[OP1_MSB:OP1_LSB];
      op2_d    = bus.instr[OP2_MSB:OP2_LSB];
      op3_d    = bus.instr[OP3_MSB:OP3_LSB];
      imm_d    = bus.instr[IMM_MSB:IMM_LSB];
    end else begin
      opcode_d = opcode_q;
    end
  end

  instr_decode u_decode (
    .opcode_i (opcode_d),
    .cls_o    (cls)
  );

  // Next-state and PC update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (cls.is_alu) begin
          state_d = S_EXEC;
        end else if (cls.is_ld || cls.is_st) begin
          state_d = S_MEM;
        end else if (cls.is_li) begin
          state_d = S_WB;
        end else if (cls.is_hlt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          if (cls.is_jmp || (cls.is_bz && bus.zero_flag)) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      S_EXEC: state_d = S_WB;
      S_MEM: begin
        if (!bus.mem_ready) begin
          state_d = S_MEM;
        end else if (cls.is_ld) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          pc_d    = pc_inc;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the upcoming state so they can be registered
  always_comb begin
    imem_rd_en_d = (state_d == S_FETCH);
    alu_en_d     = (state_d == S_EXEC);
    rf_wr_en_d   = (state_d == S_WB);
    mem_rd_en_d  = (state_d == S_MEM) && cls.is_ld;
    mem_wr_en_d  = (state_d == S_MEM) && cls.is_st;
    busy_d       = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d     = (state_d == S_HALT);
    rf_wr_sel_d  = WB_SEL_ALU;
    if (state_d == S_WB) begin
      if (cls.is_ld) begin
        rf_wr_sel_d = WB_SEL_RAM;
      end else if (cls.is_li) begin
        rf_wr_sel_d = WB_SEL_IMM;
      end else begin
        rf_wr_sel_d = WB_SEL_ALU;
      end
    end else begin
      rf_wr_sel_d = WB_SEL_ALU;
    end
    illegal_d = illegal_q || ((state_q == S_DECODE) && cls.is_illegal);
  end

  // State, PC, latched fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      opcode_q     <= 4'd0;
      op1_q        <= 3'd0;
      op2_q        <= 3'd0;
      op3_q        <= 3'd0;
      imm_q        <= 8'd0;
      imem_rd_en_q <= 1'b0;
      alu_en_q     <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_sel_q  <= 2'd0;
      mem_rd_en_q  <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      opcode_q     <= opcode_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      op3_q        <= op3_d;
      imm_q        <= imm_d;
      imem_rd_en_q <= imem_rd_en_d;
      alu_en_q     <= alu_en_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_sel_q  <= rf_wr_sel_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_wr_en_q  <= mem_wr_en_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.imem_rd_en = imem_rd_en_q;
  assign bus.opcode     = opcode_q;
  assign bus.op1        = op1_q;
  assign bus.op2        = op2_q;
  assign bus.op3        = op3_q;
  assign bus.imm        = imm_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_wr_sel  = rf_wr_sel_q;
  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_wr_en  = mem_wr_en_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; expectations adapt to CPU_SEQ_BRANCH_EN.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int PC_W = 4;
`ifdef CPU_SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] exp_pc;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(PC_W)) bus ();

  cpu_sequencer #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [20:0] mk(input logic [3:0] opc, input logic [2:0] a,
                                     input logic [2:0] b, input logic [2:0] c,
                                     input logic [7:0] im);
    return {opc, a, b, c, im};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] n_en();
    return 32'(bus.imem_rd_en) + 32'(bus.alu_en) + 32'(bus.rf_wr_en)
         + 32'(bus.mem_rd_en) + 32'(bus.mem_wr_en);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    chk("enables_exclusive", 32'(n_en() <= 32'd1), 32'd1);
  endtask

  // Two-cycle instruction from FETCH back to the next FETCH
  task automatic short_instr(input string tag, input logic [20:0] ins, input logic [3:0] next_pc);
    bus.instr = ins;
    chk({tag, "_fetch"}, 32'(bus.imem_rd_en), 32'd1);
    chk({tag, "_pc_before"}, 32'(bus.pc), 32'(exp_pc));
    step();
    chk({tag, "_decode_quiet"}, n_en(), 32'd0);
    step();
    chk({tag, "_pc_after"}, 32'(bus.pc), 32'(next_pc));
    exp_pc = next_pc;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.instr     = 21'd0;
    bus.mem_ready = 1'b0;
    bus.zero_flag = 1'b0;
    exp_pc        = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_enables", n_en(), 32'd0);
    chk("rst_flags", {29'd0, bus.busy, bus.halted, bus.illegal}, 32'd0);
    rst_n = 1'b1;

    // Idle with start low
    repeat (5) step();
    chk("idle_pc", 32'(bus.pc), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_enables", n_en(), 32'd0);

    // ALU instruction: FETCH, DECODE, EXEC, WB
    bus.instr = mk(4'b0001, 3'd1, 3'd2, 3'd3, 8'h00);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("alu_c1_imem", 32'(bus.imem_rd_en), 32'd1);
    chk("alu_c1_busy", 32'(bus.busy), 32'd1);
    step();
    chk("alu_c2_quiet", n_en(), 32'd0);
    step();
    chk("alu_c3_alu_en", 32'(bus.alu_en), 32'd1);
    chk("alu_fields", {20'd0, bus.opcode, bus.op1, bus.op2, bus.op3},
        {20'd0, 4'b0001, 3'd1, 3'd2, 3'd3});
    step();
    chk("alu_c4_rf_wr", 32'(bus.rf_wr_en), 32'd1);
    chk("alu_c4_sel", 32'(bus.rf_wr_sel), 32'd0);
    step();
    chk("alu_c5_pc", 32'(bus.pc), 32'd1);
    exp_pc = 4'd1;

    // LD with three wait cycles
    bus.instr = mk(4'b1001, 3'd4, 3'd0, 3'd0, 8'h20);
    step();
    step();
    chk("ld_mem_rd_first", 32'(bus.mem_rd_en), 32'd1);
    chk("ld_imm", 32'(bus.imm), 32'h20);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_mem_rd_wait", 32'(bus.mem_rd_en), 32'd1);
    end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("ld_wb_rf_wr", 32'(bus.rf_wr_en), 32'd1);
    chk("ld_wb_sel", 32'(bus.rf_wr_sel), 32'd2);
    chk("ld_wb_mem_rd_off", 32'(bus.mem_rd_en), 32'd0);
    step();
    chk("ld_pc", 32'(bus.pc), 32'd2);
    exp_pc = 4'd2;

    // Illegal opcode behaves as NOP and sets the sticky flag
    chk("illegal_before", 32'(bus.illegal), 32'd0);
    short_instr("ill", mk(4'b1110, 3'd0, 3'd0, 3'd0, 8'h00), exp_pc + 4'd1);
    chk("illegal_set", 32'(bus.illegal), 32'd1);

    // Branches
    bus.zero_flag = 1'b1;
    short_instr("bz_taken", mk(4'b1100, 3'd0, 3'd0, 3'd0, 8'h07), BR_EN ? 4'd7 : exp_pc + 4'd1);
    bus.zero_flag = 1'b0;
    short_instr("bz_not", mk(4'b1100, 3'd0, 3'd0, 3'd0, 8'h07), exp_pc + 4'd1);
    short_instr("jmp", mk(4'b1011, 3'd0, 3'd0, 3'd0, 8'h0F), BR_EN ? 4'd15 : exp_pc + 4'd1);
    chk("illegal_sticky", 32'(bus.illegal), 32'd1);

    // LI: FETCH, DECODE, WB
    bus.instr = mk(4'b1000, 3'd5, 3'd0, 3'd0, 8'hA5);
    step();
    step();
    chk("li_rf_wr", 32'(bus.rf_wr_en), 32'd1);
    chk("li_sel", 32'(bus.rf_wr_sel), 32'd1);
    chk("li_imm", 32'(bus.imm), 32'hA5);
    step();
    exp_pc = exp_pc + 4'd1;
    chk("li_pc", 32'(bus.pc), 32'(exp_pc));

    // Walk up to PC=15 and wrap
    for (int i = 0; i < 16; i++) begin
      if (exp_pc != 4'd15) begin
        short_instr("nop_walk", mk(4'b0000, 3'd0, 3'd0, 3'd0, 8'h00), exp_pc + 4'd1);
      end
    end
    short_instr("nop_wrap", mk(4'b0000, 3'd0, 3'd0, 3'd0, 8'h00), 4'd0);
    short_instr("nop_1", mk(4'b0000, 3'd0, 3'd0, 3'd0, 8'h00), 4'd1);

    // ST held in MEM, then asynchronous reset mid-wait
    bus.instr = mk(4'b1010, 3'd2, 3'd0, 3'd0, 8'h33);
    step();
    step();
    chk("st_mem_wr", 32'(bus.mem_wr_en), 32'd1);
    step();
    chk("st_mem_wr_wait", 32'(bus.mem_wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("st_rst_mem_wr_drop", 32'(bus.mem_wr_en), 32'd0);
    chk("st_rst_busy", 32'(bus.busy), 32'd0);
    chk("st_rst_pc", 32'(bus.pc), 32'd0);
    chk("st_rst_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", {30'd0, bus.busy, bus.imem_rd_en}, 32'd0);
    chk("post_rst_pc", 32'(bus.pc), 32'd0);
    exp_pc = 4'd0;

    // HLT at PC=1; PC frozen while start toggles
    bus.instr = mk(4'b0000, 3'd0, 3'd0, 3'd0, 8'h00);
    bus.start = 1'b1;
    step();
    short_instr("pre_hlt_nop", mk(4'b0000, 3'd0, 3'd0, 3'd0, 8'h00), 4'd1);
    bus.instr = mk(4'b1111, 3'd0, 3'd0, 3'd0, 8'h00);
    step();
    step();
    chk("hlt_halted", 32'(bus.halted), 32'd1);
    chk("hlt_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.start = ~bus.start;
      step();
      chk("hlt_pc_frozen", 32'(bus.pc), 32'd1);
      chk("hlt_stays", {30'd0, bus.halted, bus.imem_rd_en}, 32'd2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 8-bit microprocessor. Sequences each 21-bit instruction through fetch, decode, execute, memory and write-back. Owns the 4-bit program counter. Drives the enables for the program memory, register bank, ALU and data RAM, so no two datapath resources are active in the same cycle. Replaces the free-running PC and single-cycle combinational decode in the core.

## Interface
- `PC_W`, default 4: program counter width; the PC wraps at 2^PC_W.
- `clk` in 1: sole clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level input; leaves IDLE when high.
- `instr` in 21: program memory output. Field layout:
  - opcode [20:17]
  - op1 [16:14]
  - op2 [13:11]
  - op3 [10:8]
  - imm/addr [7:0]
- `mem_ready` in 1: RAM access complete; sampled in MEM.
- `zero_flag` in 1: ALU flag_out zero bit; registered by the datapath.
- `pc` out PC_W: current program counter.
- `imem_rd_en` out 1: program memory read strobe.
- `opcode` out 4: latched instruction field.
- `op1`, `op2`, `op3` out 3 each: latched instruction fields.
- `imm` out 8: latched instruction field.
- `alu_en` out 1: ALU evaluate enable.
- `rf_wr_en` out 1: register bank write strobe.
- `rf_wr_sel` out 2: write-back source. 0 = ALU, 1 = imm, 2 = RAM data.
- `mem_rd_en`, `mem_wr_en` out 1 each: data RAM enables.
- `busy` out 1: high in any state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky; set on an undefined opcode.

## Operation
- Opcodes:
  - 0000 NOP
  - 0001–0111 ALU
  - 1000 LI
  - 1001 LD
  - 1010 ST
  - 1011 JMP
  - 1100 BZ
  - 1111 HLT
  - 1101, 1110 illegal: executed as NOP, set `illegal`.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: goes to FETCH when `start`=1.
- FETCH: `imem_rd_en`=1; always goes to DECODE.
- DECODE: latches `instr` into the field registers, then branches on opcode:
  - ALU → EXEC
  - LD/ST → MEM
  - LI → WB
  - HLT → HALT
  - NOP/illegal → FETCH, with PC+1
  - JMP/BZ → FETCH, with the PC rules below.
- EXEC: `alu_en`=1; goes to WB.
- MEM:
  - `mem_rd_en`=1 for LD, `mem_wr_en`=1 for ST.
  - Held until `mem_ready`=1.
  - On `mem_ready`: LD goes to WB; ST goes to FETCH with PC+1.
- WB: `rf_wr_en`=1 for exactly one cycle. `rf_wr_sel` = 0 for ALU, 1 for LI, 2 for LD. Then FETCH with PC+1.
- HALT: terminal; exited only by reset. `start` is ignored.
- PC arithmetic: modulo 2^PC_W (15+1 → 0).
  - JMP: PC ← imm[PC_W-1:0].
  - BZ: PC ← imm[PC_W-1:0] if `zero_flag`=1, else PC+1. `zero_flag` is sampled in DECODE.
- Field outputs hold their value from DECODE until the next DECODE.
- `illegal` clears only on reset.

## Timing
- Reset value of every output is 0, state is IDLE, PC is 0.
  - Reset is asynchronous; a reset in any state, including MEM mid-wait, drops all enables immediately.
- Enables are Moore outputs, decoded from the state register and the latched opcode; there are no combinational paths from inputs to outputs.
- Cycles per instruction, zero-wait RAM:
  - ALU 4
  - LI 3
  - LD 4 (+ wait cycles)
  - ST 3 (+ wait cycles)
  - NOP/JMP/BZ 2
- `mem_ready` asserted in the first MEM cycle means zero wait. A RAM access needs only one cycle of enable.
- At most one of `alu_en`, `rf_wr_en`, `mem_rd_en`, `mem_wr_en`, `imem_rd_en` is high in any cycle.

## Configuration
- Macro `CPU_SEQ_BRANCH_EN`.
- Defined: JMP and BZ behave as specified.
- Undefined: opcodes 1011 and 1100 are treated as illegal: NOP plus `illegal`=1. `zero_flag` is unused.

## Structure
- Package `cpu_pkg`:
  - opcode constants (OP_NOP, OP_LI, OP_LD, OP_ST, OP_JMP, OP_BZ, OP_HLT, ALU range bounds)
  - state enum type
  - `rf_wr_sel` encodings
  - field bit positions.
- One sub-module, `instr_decode`: purely combinational classification of the opcode into {is_alu, is_li, is_ld, is_st, is_jmp, is_bz, is_hlt, is_illegal}. The FSM and PC stay in `cpu_sequencer`.

## Test plan
- Reset and idle: reset, `start`=0 for 5 cycles → PC=0, all enables 0, `busy`=0.
- ALU instruction: `start`=1, instr opcode 0001 → `imem_rd_en` at cycle 1, `alu_en` at 3, `rf_wr_en` with sel 0 at 4, PC=1 at cycle 5.
- LD with waits: instr opcode 1001, imm 0x20, `mem_ready` held low 3 cycles → `mem_rd_en` high 4 cycles, then `rf_wr_en` with sel 2, PC+1.
- Branch and wrap:
  - BZ imm 0x07 with `zero_flag`=1 → PC=7.
  - BZ with `zero_flag`=0 → PC+1.
  - NOP at PC=15 → PC=0.
- HLT and illegal:
  - opcode 1110 → `illegal`=1, PC+1.
  - HLT → `halted`=1 and PC frozen while `start` toggles.
- Reset mid-MEM: assert `rst_n`=0 during a ST wait → `mem_wr_en` drops asynchronously; state is IDLE and PC=0 after release.
